signed_serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor: computes d = a - b on WIDTH-bit signed operands and flags signed overflow.
- Performs the inverse operation of the team's combinational signed adder.
- Trades latency (one bit per cycle) for area, for narrow datapaths that can afford multi-cycle arithmetic.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/signed_arith_pkg.sv | 10 +
 rtl/serial_sub_bit.sv | 14 +
 rtl/signed_serial_subtractor.sv | 90 +++++++++
 tb/tb_signed_serial_subtractor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/signed_arith_pkg.sv
// Shared types and constants for the signed arithmetic blocks (adder/subtractor family).
package signed_arith_pkg;
  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sub_state_t;
endpackage

// File: rtl/serial_sub_bit.sv
// One-bit subtract cell: computes a_bit + ~b_bit + c_in, giving a sum bit and a carry out.
module serial_sub_bit (
  input  logic a_bit,
  input  logic b_bit,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  logic b_inv;

  assign b_inv = ~b_bit;
  assign s     = a_bit ^ b_inv ^ c_in;
  assign c_out = (a_bit & b_inv) | (a_bit & c_in) | (b_inv & c_in);
endmodule

// File: rtl/signed_serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b with signed overflow flag.
// Processes one bit per cycle, LSB first, with valid/ready on both sides.
module signed_serial_subtractor
  import signed_arith_pkg::*;
#(
  parameter  int WIDTH = ARITH_W,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             overflow
);
  sub_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             a_sign, b_sign;
  logic             s_bit, c_bit;
  logic             last_bit;

  serial_sub_bit u_bit (
    .a_bit (a_sh[0]),
    .b_bit (b_sh[0]),
    .c_in  (carry),
    .s     (s_bit),
    .c_out (c_bit)
  );

  assign last_bit  = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));
  assign r_next    = {s_bit, r_sh};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control: FSM, bit counter, carry and the registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b1;
      d        <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        cnt   <= '0;
        carry <= 1'b1;
      end else if (state == BUSY) begin
        cnt   <= cnt + CNT_W'(1);
        carry <= c_bit;
        if (last_bit) begin
          d        <= r_next;
          overflow <= (a_sign != b_sign) && (s_bit != a_sign);
        end
      end
    end
  end

  // Datapath: operand shifters and partial result, no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_sh   <= a;
      b_sh   <= b;
      a_sign <= a[WIDTH-1];
      b_sign <= b[WIDTH-1];
    end else if (state == BUSY) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      r_sh <= r_next[WIDTH-1:1];
    end
  end
endmodule

// File: tb/tb_signed_serial_subtractor.sv
// Directed and model-checked stimulus for the bit-serial signed subtractor.
module tb_signed_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             overflow;

  int tests = 0;
  int fails = 0;

  signed_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (!in_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Full transaction with out_ready held high; checks latency and single-cycle valid.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] exp_d, input logic exp_ovf);
    int cyc;
    wait_ready(tag);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    wait_result(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    check({tag, "_d"}, 32'(d), 32'(exp_d));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    tick();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int xi, yi, di;
    logic [WIDTH-1:0] r;
    logic             o;
    xi = int'($signed(x));
    yi = int'($signed(y));
    di = xi - yi;
    r  = WIDTH'(di);
    o  = (di > (2 ** (WIDTH - 1)) - 1) || (di < -(2 ** (WIDTH - 1)));
    return {o, r};
  endfunction

  initial begin
    int cyc;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH:0]   exp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    run_op("pos_small", 8'h05, 8'h03, 8'h02, 1'b0);
    run_op("neg_ovf",   8'h80, 8'h01, 8'h7F, 1'b1);
    run_op("pos_ovf",   8'h7F, 8'hFF, 8'h80, 1'b1);
    run_op("neg_res",   8'hFB, 8'h03, 8'hF8, 1'b0);
    run_op("zero",      8'h00, 8'h00, 8'h00, 1'b0);
    run_op("min_min",   8'h80, 8'h80, 8'h00, 1'b0);
    run_op("max_min",   8'h7F, 8'h80, 8'hFF, 1'b1);

    // Backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    wait_ready("bp");
    a = 8'hF0;
    b = 8'h20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(cyc);
    check("bp_latency", 32'(cyc), 32'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_d", 32'(d), 32'hD0);
      check("bp_hold_ovf", 32'(overflow), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Operands offered during BUSY must be ignored
    wait_ready("busy");
    a = 8'h30;
    b = 8'h10;
    in_valid = 1'b1;
    tick();
    a = 8'h01;
    b = 8'h7F;
    repeat (3) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    wait_result(cyc);
    check("busy_latency", 32'(cyc), 32'(WIDTH - 3));
    check("busy_d", 32'(d), 32'h20);
    check("busy_ovf", 32'(overflow), 32'd0);
    tick();

    for (int i = 0; i < 20; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      exp = ref_sub(ra, rb);
      run_op($sformatf("rnd%0d", i), ra, rb, exp[WIDTH-1:0], exp[WIDTH]);
    end

    // Abort partway through BUSY
    wait_ready("abort");
    a = 8'h55;
    b = 8'h11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run_op("after_abort", 8'd10, 8'd20, 8'hF6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
